// File: rtl/ctrl_microondas_param.sv
// Microwave controller: time/power entry, 1 s countdown, door interlock,
// duty-cycled heater drive and a timed done indication.
module ctrl_microondas_param #(
  parameter int TICK_DIV   = 100000000,
  parameter int MAX_MIN    = 99,
  parameter int MW         = 7,
  parameter int N_POWER    = 3,
  parameter int PW         = 2,
  parameter int DONE_TICKS = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic          pause,
  input  logic          door,
  input  logic          plus,
  input  logic          minus,
  input  logic          power_sel,
  input  logic [1:0]    step_mode,
  output logic [MW-1:0] min,
  output logic [5:0]    sec,
  output logic [PW-1:0] power_lvl,
  output logic [1:0]    state,
  output logic          heating,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int CW = $clog2(TICK_DIV);
  localparam int DW = (DONE_TICKS > 1) ? $clog2(DONE_TICKS) : 1;
  localparam int XW = MW + 5;

  state_t        r_state, w_nx_state;
  logic [MW-1:0] r_min, w_nx_min;
  logic [5:0]    r_sec, w_nx_sec;
  logic [PW-1:0] r_pwr, w_nx_pwr;
  logic [CW-1:0] r_cnt, w_nx_cnt;
  logic [PW-1:0] r_ph, w_nx_ph;
  logic [DW-1:0] r_dn, w_nx_dn;
  logic          r_heat, w_nx_heat;
  logic          r_start_q, r_stop_q, r_pause_q;
  logic          r_plus_q, r_minus_q;

  logic          w_e_start, w_e_stop, w_e_pause;
  logic          w_e_plus, w_e_minus;
  logic          w_tick, w_tpos, w_tone;
  logic [5:0]    w_small;
  logic [XW-1:0] w_big;
  logic [XW-1:0] w_up_m, w_dn_m;
  logic [6:0]    w_up_s, w_dn_s;
  logic [PW-1:0] w_p_up, w_p_dn, w_ph_inc;
  logic [MW-1:0] w_cd_m;
  logic [5:0]    w_cd_s;

  assign w_e_start = start & ~r_start_q;
  assign w_e_stop  = stop  & ~r_stop_q;
  assign w_e_pause = pause & ~r_pause_q;
  assign w_e_plus  = plus  & ~r_plus_q;
  assign w_e_minus = minus & ~r_minus_q;

  assign w_tick = (r_cnt == CW'(TICK_DIV - 1));
  assign w_tpos = (r_min != '0) || (r_sec != '0);
  assign w_tone = (r_min == '0) && (r_sec == 6'd1);

  assign w_p_up = (r_pwr == PW'(N_POWER - 1)) ? r_pwr : r_pwr + 1'b1;
  assign w_p_dn = (r_pwr == '0) ? r_pwr : r_pwr - 1'b1;
  assign w_ph_inc = (r_ph == PW'(N_POWER - 1)) ? '0 : r_ph + 1'b1;

  assign w_cd_m = (r_sec == '0) ? r_min - 1'b1 : r_min;
  assign w_cd_s = (r_sec == '0) ? 6'd59 : r_sec - 6'd1;

  // Steps split into a seconds part and a whole-minutes part
  always_comb begin
    w_small = '0;
    w_big   = '0;
    unique case (step_mode)
      2'b00:   w_small = 6'd1;
      2'b01:   w_small = 6'd10;
      2'b10:   w_big   = XW'(1);
      default: w_big   = XW'(10);
    endcase
    w_up_m = XW'(r_min) + w_big;
    w_up_s = {1'b0, r_sec} + {1'b0, w_small};
    if (w_up_s >= 7'd60) begin
      w_up_s = w_up_s - 7'd60;
      w_up_m = w_up_m + 1'b1;
    end
    if (w_up_m > XW'(MAX_MIN)) begin
      w_up_m = XW'(MAX_MIN);
      w_up_s = 7'd59;
    end
    w_dn_m = XW'(r_min);
    w_dn_s = {1'b0, r_sec};
    if ((XW'(r_min) < w_big) ||
        ((r_min == '0) && (r_sec < w_small))) begin
      w_dn_m = '0;
      w_dn_s = '0;
    end else if (r_sec >= w_small) begin
      w_dn_m = XW'(r_min) - w_big;
      w_dn_s = {1'b0, r_sec - w_small};
    end else begin
      w_dn_m = XW'(r_min) - XW'(1);
      w_dn_s = {1'b0, r_sec} + 7'd60 - {1'b0, w_small};
    end
  end

  always_comb begin
    w_nx_state = r_state;
    w_nx_min   = r_min;
    w_nx_sec   = r_sec;
    w_nx_pwr   = r_pwr;
    w_nx_cnt   = r_cnt;
    w_nx_ph    = r_ph;
    w_nx_dn    = r_dn;
    unique case (r_state)
      S_IDLE: begin
        if (w_e_start && !door && w_tpos) begin
          w_nx_state = S_RUN;
          w_nx_cnt   = '0;
          w_nx_ph    = '0;
        end else if (w_e_plus ^ w_e_minus) begin
          if (power_sel) begin
            w_nx_pwr = w_e_plus ? w_p_up : w_p_dn;
          end else begin
            w_nx_min = MW'(w_e_plus ? w_up_m : w_dn_m);
            w_nx_sec = 6'(w_e_plus ? w_up_s : w_dn_s);
          end
        end
      end
      S_RUN: begin
        if (w_e_stop) begin
          w_nx_state = S_IDLE;
          w_nx_min   = '0;
          w_nx_sec   = '0;
        end else if (w_e_pause || door) begin
          w_nx_state = S_PAUSE;
        end else if (w_tick) begin
          w_nx_cnt = '0;
          w_nx_ph  = w_ph_inc;
          if (w_tone) begin
            w_nx_state = S_DONE;
            w_nx_min   = '0;
            w_nx_sec   = '0;
            w_nx_dn    = '0;
          end else begin
            w_nx_min = w_cd_m;
            w_nx_sec = w_cd_s;
          end
        end else begin
          w_nx_cnt = r_cnt + 1'b1;
        end
      end
      S_PAUSE: begin
        if (w_e_stop) begin
          w_nx_state = S_IDLE;
          w_nx_min   = '0;
          w_nx_sec   = '0;
        end else if ((w_e_start || w_e_pause) && !door) begin
          w_nx_state = S_RUN;
        end
      end
      default: begin
        if (w_e_stop || w_e_start || w_e_pause) begin
          w_nx_state = S_IDLE;
        end else if (w_tick) begin
          w_nx_cnt = '0;
          if (r_dn == DW'(DONE_TICKS - 1)) w_nx_state = S_IDLE;
          else w_nx_dn = r_dn + 1'b1;
        end else begin
          w_nx_cnt = r_cnt + 1'b1;
        end
      end
    endcase
    w_nx_heat = (w_nx_state == S_RUN) && (w_nx_ph <= w_nx_pwr);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_min     <= '0;
      r_sec     <= '0;
      r_pwr     <= '0;
      r_cnt     <= '0;
      r_ph      <= '0;
      r_dn      <= '0;
      r_heat    <= 1'b0;
      r_start_q <= 1'b0;
      r_stop_q  <= 1'b0;
      r_pause_q <= 1'b0;
      r_plus_q  <= 1'b0;
      r_minus_q <= 1'b0;
    end else begin
      r_state   <= w_nx_state;
      r_min     <= w_nx_min;
      r_sec     <= w_nx_sec;
      r_pwr     <= w_nx_pwr;
      r_cnt     <= w_nx_cnt;
      r_ph      <= w_nx_ph;
      r_dn      <= w_nx_dn;
      r_heat    <= w_nx_heat;
      r_start_q <= start;
      r_stop_q  <= stop;
      r_pause_q <= pause;
      r_plus_q  <= plus;
      r_minus_q <= minus;
    end
  end

  assign min       = r_min;
  assign sec       = r_sec;
  assign power_lvl = r_pwr;
  assign state     = r_state;
  assign heating   = r_heat;
  assign done      = (r_state == S_DONE);

endmodule
